life_grid_renderer: RTL and testbench

//  Pixel stage between VGA_DRIVER_480p and the VGA pins.
//  - Maps each (sx,sy) pixel to a cell of the Game of Life grid.
//  - Reads that cell's state from the synchronous cell RAM and drives registered 4-bit RGB.
//  - Delays hsync/vsync by the same amount so colour and sync stay aligned.
//  - Requests one CELLULAR_AUTOMATA generation step per frame, issued in vertical blanking.

---
 rtl/life_grid_renderer.sv | 209 ++++++++++++++++++++
 tb/tb_life_grid_renderer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/life_grid_renderer.sv
// life_grid_renderer: maps VGA pixels onto the Life grid, reads each cell from the
// synchronous cell RAM and drives aligned RGB/sync. Optional macro GRID_LINES_EN draws cell borders.
module life_grid_renderer #(
  parameter int          GRID_W    = 32,
  parameter int          GRID_H    = 32,
  parameter int          CELL_PX   = 15,
  parameter int          ADDR_W    = 10,
  parameter int          V_ACTIVE  = 480,
  parameter logic [11:0] ALIVE_RGB = 12'hFFF,
  parameter logic [11:0] DEAD_RGB  = 12'h000,
  parameter logic [11:0] OUT_RGB   = 12'h222
) (
  input  logic              clk_vga,
  input  logic              rst,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic              de,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              run,
  output logic [ADDR_W-1:0] cell_rd_addr,
  input  logic              cell_rd_data,
  output logic              gen_req,
  input  logic              gen_ack,
  output logic              gen_ovr,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync
);

  localparam int SUB_W = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int COL_W = $clog2(GRID_W + 1);
  localparam int ROW_W = $clog2(GRID_H + 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(GRID_W);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(GRID_H);
  localparam logic [9:0]       SX_LAST  = 10'd639;
  localparam logic [9:0]       SY_BOUND = 10'(V_ACTIVE);
  localparam logic [11:0]      LINE_RGB = 12'h444;
`ifdef GRID_LINES_EN
  localparam logic LINES_ON = 1'b1;
`else
  localparam logic LINES_ON = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} gen_state_t;

  logic [SUB_W-1:0]  px_sub_r, py_sub_r, px_cur_s, py_cur_s, px_nxt_s, py_nxt_s;
  logic [COL_W-1:0]  col_r, col_cur_s, col_nxt_s;
  logic [ROW_W-1:0]  row_r, row_cur_s, row_nxt_s;
  logic              synced_r, frame_start_s, boundary_s, in_grid_s, line_s;
  logic [ADDR_W-1:0] addr_s;
  logic              in1_r, de1_r, line1_r, in2_r, de2_r, line2_r;
  logic [2:0]        hs_sh_r, vs_sh_r;
  logic [11:0]       rgb_r, rgb_nxt_s;
  gen_state_t        state_r, state_nxt_s;
  logic              gen_req_r, gen_ovr_r, ovr_nxt_s;

  // Current-pixel cell coordinates and their values for the following pixel
  always_comb begin
    frame_start_s = (sx == 10'd0) && (sy == 10'd0);
    boundary_s    = (sx == 10'd0) && (sy == SY_BOUND);
    if (sx == 10'd0) begin
      px_cur_s  = {SUB_W{1'b0}};
      col_cur_s = {COL_W{1'b0}};
    end else begin
      px_cur_s  = px_sub_r;
      col_cur_s = col_r;
    end
    if (frame_start_s) begin
      py_cur_s  = {SUB_W{1'b0}};
      row_cur_s = {ROW_W{1'b0}};
    end else begin
      py_cur_s  = py_sub_r;
      row_cur_s = row_r;
    end
    px_nxt_s  = px_cur_s;
    col_nxt_s = col_cur_s;
    py_nxt_s  = py_cur_s;
    row_nxt_s = row_cur_s;
    // col/row saturate one past the grid so the right and bottom margins never alias back in
    if (de) begin
      if (px_cur_s == SUB_LAST) begin
        px_nxt_s = {SUB_W{1'b0}};
        if (col_cur_s != COL_MAX) col_nxt_s = col_cur_s + COL_W'(1);
        else                      col_nxt_s = col_cur_s;
      end else begin
        px_nxt_s = px_cur_s + SUB_W'(1);
      end
    end else begin
      px_nxt_s = px_cur_s;
    end
    if (de && (sx == SX_LAST)) begin
      if (py_cur_s == SUB_LAST) begin
        py_nxt_s = {SUB_W{1'b0}};
        if (row_cur_s != ROW_MAX) row_nxt_s = row_cur_s + ROW_W'(1);
        else                      row_nxt_s = row_cur_s;
      end else begin
        py_nxt_s = py_cur_s + SUB_W'(1);
      end
    end else begin
      py_nxt_s = py_cur_s;
    end
    in_grid_s = de && (col_cur_s < COL_MAX) && (row_cur_s < ROW_MAX);
    addr_s    = ADDR_W'(row_cur_s) * ADDR_W'(GRID_W) + ADDR_W'(col_cur_s);
    line_s    = LINES_ON && ((px_cur_s == {SUB_W{1'b0}}) || (py_cur_s == {SUB_W{1'b0}}));
  end

  // Pixel/line position counters and frame-sync flag
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      px_sub_r <= {SUB_W{1'b0}};
      col_r    <= {COL_W{1'b0}};
      py_sub_r <= {SUB_W{1'b0}};
      row_r    <= {ROW_W{1'b0}};
      synced_r <= 1'b0;
    end else begin
      px_sub_r <= px_nxt_s;
      col_r    <= col_nxt_s;
      py_sub_r <= py_nxt_s;
      row_r    <= row_nxt_s;
      synced_r <= synced_r | frame_start_s;
    end
  end

  // Final colour choice; the RAM output lines up with the stage-2 flags
  always_comb begin
    rgb_nxt_s = 12'h000;
    if (!de2_r)            rgb_nxt_s = 12'h000;
    else if (!in2_r)       rgb_nxt_s = OUT_RGB;
    else if (line2_r)      rgb_nxt_s = LINE_RGB;
    else if (cell_rd_data) rgb_nxt_s = ALIVE_RGB;
    else                   rgb_nxt_s = DEAD_RGB;
  end

  // Three-stage colour pipeline with matching sync delay
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      cell_rd_addr <= {ADDR_W{1'b0}};
      in1_r        <= 1'b0;
      de1_r        <= 1'b0;
      line1_r      <= 1'b0;
      in2_r        <= 1'b0;
      de2_r        <= 1'b0;
      line2_r      <= 1'b0;
      rgb_r        <= 12'h000;
      hs_sh_r      <= 3'b000;
      vs_sh_r      <= 3'b000;
    end else begin
      cell_rd_addr <= addr_s;
      in1_r        <= in_grid_s;
      de1_r        <= de && (synced_r || frame_start_s);
      line1_r      <= line_s;
      in2_r        <= in1_r;
      de2_r        <= de1_r;
      line2_r      <= line1_r;
      rgb_r        <= rgb_nxt_s;
      hs_sh_r      <= {hs_sh_r[1:0], hsync_in};
      vs_sh_r      <= {vs_sh_r[1:0], vsync_in};
    end
  end

  // Generation handshake next state; an ack beats a coincident frame boundary
  always_comb begin
    state_nxt_s = state_r;
    ovr_nxt_s   = gen_ovr_r;
    case (state_r)
      IDLE: begin
        if (boundary_s && run) state_nxt_s = REQ;
        else                   state_nxt_s = IDLE;
      end
      REQ: begin
        if (gen_ack) begin
          state_nxt_s = IDLE;
        end else if (boundary_s) begin
          state_nxt_s = REQ;
          ovr_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = REQ;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake state and registered request/overrun outputs
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      gen_req_r <= 1'b0;
      gen_ovr_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      gen_req_r <= (state_nxt_s == REQ);
      gen_ovr_r <= ovr_nxt_s;
    end
  end

  assign gen_req   = gen_req_r;
  assign gen_ovr   = gen_ovr_r;
  assign vga_r     = rgb_r[11:8];
  assign vga_g     = rgb_r[7:4];
  assign vga_b     = rgb_r[3:0];
  assign vga_hsync = hs_sh_r[2];
  assign vga_vsync = vs_sh_r[2];

endmodule

// File: tb/tb_life_grid_renderer.sv
// Directed bench for life_grid_renderer: RAM model, independent pixel-colour model
// and generation-handshake sequences.
module tb_life_grid_renderer;

  logic       clk_vga, rst;
  logic [9:0] sx, sy;
  logic       de, hsync_in, vsync_in, run;
  logic [9:0] cell_rd_addr;
  logic       cell_rd_data, gen_req, gen_ack, gen_ovr;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync;

  int checks = 0;
  int errors = 0;

  logic        mem [0:1023];
  logic        synced_m;
  logic [11:0] e_rgb [0:2];
  logic        e_chk [0:2];
  logic        e_hs  [0:2];
  logic        e_vs  [0:2];
  int          e_x   [0:2];
  int          e_y   [0:2];

  life_grid_renderer dut (
    .clk_vga(clk_vga), .rst(rst), .sx(sx), .sy(sy), .de(de),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .run(run),
    .cell_rd_addr(cell_rd_addr), .cell_rd_data(cell_rd_data),
    .gen_req(gen_req), .gen_ack(gen_ack), .gen_ovr(gen_ovr),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  // Synchronous cell RAM: data one cycle after address
  always @(posedge clk_vga) cell_rd_data <= mem[cell_rd_addr];

  function automatic logic [11:0] model_rgb(input int x, input int y, input logic d, input logic ok);
    int c, r;
    c = x / 15;
    r = y / 15;
    if (!d || !ok) return 12'h000;
    if (c >= 32 || r >= 32) return 12'h222;
`ifdef GRID_LINES_EN
    if ((x % 15) == 0 || (y % 15) == 0) return 12'h444;
`endif
    return mem[r * 32 + c] ? 12'hFFF : 12'h000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    synced_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e_rgb[i] = 12'h000; e_chk[i] = 1'b0; e_hs[i] = 1'b0; e_vs[i] = 1'b0;
      e_x[i] = 0; e_y[i] = 0;
    end
  endtask

  // One pixel clock; outputs after the edge belong to the pixel driven two steps earlier
  task automatic step(input int x, input int y, input logic d, input logic hs, input logic vs,
                      input logic chk_en);
    sx = 10'(x); sy = 10'(y); de = d; hsync_in = hs; vsync_in = vs;
    if (x == 0 && y == 0) synced_m = 1'b1;
    for (int i = 2; i > 0; i--) begin
      e_rgb[i] = e_rgb[i-1]; e_chk[i] = e_chk[i-1]; e_hs[i] = e_hs[i-1];
      e_vs[i] = e_vs[i-1]; e_x[i] = e_x[i-1]; e_y[i] = e_y[i-1];
    end
    e_rgb[0] = model_rgb(x, y, d, synced_m);
    e_chk[0] = chk_en; e_hs[0] = hs; e_vs[0] = vs; e_x[0] = x; e_y[0] = y;
    @(posedge clk_vga); #1;
    if (e_chk[2]) begin
      check($sformatf("rgb(%0d,%0d)", e_x[2], e_y[2]), {20'd0, vga_r, vga_g, vga_b}, {20'd0, e_rgb[2]});
      check($sformatf("hsync(%0d,%0d)", e_x[2], e_y[2]), {31'd0, vga_hsync}, {31'd0, e_hs[2]});
      check($sformatf("vsync(%0d,%0d)", e_x[2], e_y[2]), {31'd0, vga_vsync}, {31'd0, e_vs[2]});
    end
  endtask

  task automatic fast_line(input int y);
    step(0, y, 1'b1, 1'b1, 1'b1, 1'b0);
    step(639, y, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; sx = 10'd0; sy = 10'd0; de = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    run = 1'b0; gen_ack = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
    mem[0] = 1'b1;
    clear_model();
    repeat (3) @(posedge clk_vga);
    #1;
    check("reset_outputs", {6'd0, cell_rd_addr, gen_req, gen_ovr, vga_r, vga_g, vga_b,
                            vga_hsync, vga_vsync}, 32'd0);
    rst = 1'b0;

    // Before any frame start the picture stays black
    for (int x = 0; x < 10; x++) step(x, 5, 1'b1, 1'b1, 1'b1, 1'b1);

    // First line: cell 0 alive, cell 1 dead, right margin grey
    for (int x = 0; x < 640; x++) begin
      step(x, 0, 1'b1, 1'b1, 1'b1, 1'b1);
      if (x == 0)  check("addr(0,0)", {22'd0, cell_rd_addr}, 32'd0);
      if (x == 15) check("addr(15,0)", {22'd0, cell_rd_addr}, 32'd1);
    end

    // Cell 1 alive, look at line 3 across the cell 0/1 border
    mem[1] = 1'b1;
    fast_line(1);
    fast_line(2);
    for (int x = 0; x < 21; x++) step(x, 3, 1'b1, 1'b1, 1'b1, 1'b1);
    step(639, 3, 1'b1, 1'b1, 1'b1, 1'b0);

    for (int y = 4; y < 15; y++) fast_line(y);
    for (int x = 0; x < 16; x++) begin
      step(x, 15, 1'b1, 1'b1, 1'b1, 1'b1);
      if (x == 15) check("addr(15,15)", {22'd0, cell_rd_addr}, 32'd33);
    end
    step(639, 15, 1'b1, 1'b1, 1'b1, 1'b0);

    for (int y = 16; y < 479; y++) fast_line(y);
    for (int x = 0; x < 491; x++) begin
      step(x, 479, 1'b1, 1'b1, 1'b1, 1'b1);
      if (x == 479) check("addr(479,479)", {22'd0, cell_rd_addr}, 32'd1023);
    end

    // Horizontal blanking with an hsync pulse
    for (int x = 640; x < 760; x++) step(x, 479, 1'b0, (x >= 656 && x < 752) ? 1'b0 : 1'b1, 1'b1, 1'b1);

    // Request raised at the blanking boundary, overrun on the next boundary
    check("gen_req_idle", {31'd0, gen_req}, 32'd0);
    run = 1'b1;
    step(0, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    check("gen_req_rise", {31'd0, gen_req}, 32'd1);
    check("gen_ovr_first", {31'd0, gen_ovr}, 32'd0);
    step(1, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("gen_ovr_framestart", {31'd0, gen_ovr}, 32'd0);
    step(0, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    check("gen_ovr_set", {31'd0, gen_ovr}, 32'd1);
    check("gen_req_held", {31'd0, gen_req}, 32'd1);
    gen_ack = 1'b1;
    step(1, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    gen_ack = 1'b0;
    check("gen_req_ack_fall", {31'd0, gen_req}, 32'd0);
    check("gen_ovr_sticky", {31'd0, gen_ovr}, 32'd1);
    gen_ack = 1'b1;
    step(2, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    gen_ack = 1'b0;
    check("ack_in_idle", {31'd0, gen_req}, 32'd0);

    // Ack coincident with a boundary returns to idle for that frame
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(0, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    check("gen_req_rise2", {31'd0, gen_req}, 32'd1);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    gen_ack = 1'b1;
    step(0, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    gen_ack = 1'b0;
    check("ack_on_boundary", {31'd0, gen_req}, 32'd0);
    for (int x = 1; x < 5; x++) step(x, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    check("no_req_same_frame", {31'd0, gen_req}, 32'd0);

    // run dropped while requesting: request held until acked
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(0, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    run = 1'b0;
    step(1, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(0, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    check("req_held_run_low", {31'd0, gen_req}, 32'd1);
    gen_ack = 1'b1;
    step(1, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    gen_ack = 1'b0;
    check("req_ack_run_low", {31'd0, gen_req}, 32'd0);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(0, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    check("run_low_no_req", {31'd0, gen_req}, 32'd0);

    // Asynchronous reset in the middle of a visible line
    run = 1'b1;
    step(0, 480, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int x = 0; x < 6; x++) step(x, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("reset_async", {6'd0, cell_rd_addr, gen_req, gen_ovr, vga_r, vga_g, vga_b,
                          vga_hsync, vga_vsync}, 32'd0);
    run = 1'b0;
    clear_model();
    @(posedge clk_vga); #1;
    rst = 1'b0;
    for (int x = 0; x < 11; x++) step(x, 7, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int x = 0; x < 23; x++) step(x, 0, 1'b1, 1'b1, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
